// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state encodings and defaults for the memory bus arbiter
package mem_bus_arbiter_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_MEM  = 2'd2
    } arb_state_e;
    localparam int MAX_MEM_STREAK_DEF = 4;
    localparam int TIMEOUT_CYCLES_DEF = 64;
    localparam logic [3:0] IF_SEL = 4'hF;
endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// arb_timeout_cnt: clearable saturating counter with terminal-count flag
module arb_timeout_cnt #(
    parameter int MAX = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign tc_o  = (cnt_q == W'(MAX));
    assign cnt_d = clr_i ? '0 : (en_i && !tc_o) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between fetch and load/store,
// MEM-priority with an IF anti-starvation limit, flush drop and timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_MEM_STREAK = MAX_MEM_STREAK_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic        if_ack_o,
    output logic        if_err_o,
    output logic [31:0] if_rdata_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_sel_i,
    output logic        mem_ack_o,
    output logic        mem_err_o,
    output logic [31:0] mem_rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stallreq_if_o,
    output logic        stallreq_mem_o
);
    localparam int SW = $clog2(MAX_MEM_STREAK + 1);
    arb_state_e state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          drop_q, drop_d, we_q, we_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]    sel_q, sel_d;
    logic          if_live, grant_mem, grant_if, busy, tc, tmo, done;
    assign if_live   = if_req_i & ~if_flush_i;
    assign grant_mem = (state_q == ARB_IDLE) & mem_req_i & ~(if_live & (streak_q == SW'(MAX_MEM_STREAK)));
    assign grant_if  = (state_q == ARB_IDLE) & ~grant_mem & if_live;
    assign busy      = (state_q != ARB_IDLE);
    assign tmo       = busy & ~bus_ack_i & tc;
    assign done      = busy & (bus_ack_i | tmo);
    // Held cleared through IDLE so every grant starts from zero.
    arb_timeout_cnt #(.MAX(TIMEOUT_CYCLES - 1)) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .clr_i (~busy),
        .en_i  (busy & ~bus_ack_i),
        .tc_o  (tc)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            streak_q <= '0;
            drop_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            drop_q   <= drop_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
        end
    end
    always_comb begin
        state_d  = grant_mem ? ARB_MEM : grant_if ? ARB_IF : done ? ARB_IDLE : state_q;
        streak_d = grant_if ? '0 :
                   grant_mem ? (if_live ? ((streak_q == SW'(MAX_MEM_STREAK)) ? streak_q : streak_q + SW'(1)) : '0) :
                   streak_q;
        drop_d   = (grant_mem | grant_if) ? 1'b0 : (state_q == ARB_IF) ? (drop_q | if_flush_i) : drop_q;
        addr_d   = grant_mem ? mem_addr_i : grant_if ? if_addr_i : addr_q;
        we_d     = grant_mem ? mem_we_i : grant_if ? 1'b0 : we_q;
        wdata_d  = grant_mem ? mem_wdata_i : grant_if ? 32'd0 : wdata_q;
        sel_d    = grant_mem ? mem_sel_i : grant_if ? IF_SEL : sel_q;
    end
    always_comb begin
        if_ack_o       = (state_q == ARB_IF) & done & ~drop_q;
        mem_ack_o      = (state_q == ARB_MEM) & done;
        if_err_o       = if_ack_o & tmo;
        mem_err_o      = mem_ack_o & tmo;
        if_rdata_o     = (if_ack_o & bus_ack_i) ? bus_rdata_i : 32'd0;
        mem_rdata_o    = (mem_ack_o & bus_ack_i) ? bus_rdata_i : 32'd0;
        bus_req_o      = busy;
        bus_we_o       = busy & we_q;
        bus_addr_o     = busy ? addr_q : 32'd0;
        bus_wdata_o    = busy ? wdata_q : 32'd0;
        bus_sel_o      = busy ? sel_q : 4'd0;
        stallreq_if_o  = if_req_i & ~if_ack_o;
        stallreq_mem_o = mem_req_i & ~mem_ack_o;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table plus corner sequences, acks checked against a scoreboard
module tb_mem_bus_arbiter;
    localparam int TO = 8;
    logic        clk = 1'b0, rst;
    logic        if_req_i, if_flush_i, if_ack_o, if_err_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        mem_req_i, mem_we_i, mem_ack_o, mem_err_o;
    logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
    logic [3:0]  mem_sel_i, bus_sel_o;
    logic        bus_req_o, bus_we_o, bus_ack_i;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic        stallreq_if_o, stallreq_mem_o;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MAX_MEM_STREAK(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_ack_o(if_ack_o), .if_err_o(if_err_o), .if_rdata_o(if_rdata_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_sel_i(mem_sel_i),
        .mem_ack_o(mem_ack_o), .mem_err_o(mem_err_o), .mem_rdata_o(mem_rdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o)
    );

    typedef struct {
        bit          is_mem;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] rdata;
        int          delay;
        bit          exp_we;
        logic [3:0]  exp_sel;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0, n_err = 0;

    task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Every owner ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        #2;
        if (if_ack_o || mem_ack_o) begin
            if (sb.size() == 0) check("unexpected_ack", {if_ack_o, mem_ack_o}, 0);
            else begin
                mon_e = sb.pop_front();
                check("ack_owner", {if_ack_o, mem_ack_o}, mon_e.is_mem ? 2'b01 : 2'b10);
                check("ack_err", if_err_o | mem_err_o, mon_e.err);
                check("ack_rdata", if_rdata_o | mem_rdata_o, mon_e.rdata);
            end
        end else check("idle_outputs", {if_rdata_o, mem_rdata_o, if_err_o, mem_err_o}, 0);
    end

    task automatic push(bit is_mem, bit err, logic [31:0] rd);
        exp_t e;
        e.is_mem = is_mem;
        e.err    = err;
        e.rdata  = rd;
        sb.push_back(e);
    endtask

    task automatic wait_busy(string nm);
        int n = 0;
        #2;
        while (!bus_req_o && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        check({nm, "_grant_latency"}, n, 1);
    endtask

    task automatic slave_ack(int delay, logic [31:0] rd, bit is_mem, string nm);
        repeat (delay) @(negedge clk);
        bus_ack_i   = 1'b1;
        bus_rdata_i = rd;
        #2;
        check({nm, "_ack_cycle"}, is_mem ? mem_ack_o : if_ack_o, 1);
        check({nm, "_stall_clear"}, is_mem ? stallreq_mem_o : stallreq_if_o, 0);
        @(negedge clk);
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'd0;
    endtask

    task automatic do_txn(vec_t v);
        @(negedge clk);
        if (v.is_mem) begin
            mem_req_i   = 1'b1;
            mem_we_i    = v.we;
            mem_addr_i  = v.addr;
            mem_wdata_i = v.wdata;
            mem_sel_i   = v.sel;
        end else begin
            if_req_i  = 1'b1;
            if_addr_i = v.addr;
        end
        push(v.is_mem, 1'b0, v.rdata);
        wait_busy("vec");
        check("vec_bus_fields", {bus_addr_o, bus_we_o, bus_sel_o}, {v.addr, v.exp_we, v.exp_sel});
        if (v.is_mem) check("vec_bus_wdata", bus_wdata_o, v.wdata);
        check("vec_stall_busy", v.is_mem ? stallreq_mem_o : stallreq_if_o, 1);
        slave_ack(v.delay, v.rdata, v.is_mem, "vec");
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
        mem_req_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_sel_i = 0;
        bus_ack_i = 0; bus_rdata_i = 0;
        vecs[0] = '{0, 0, 32'h100,  32'h0,        4'h0, 32'h11112222, 3, 0, 4'hF};
        vecs[1] = '{1, 0, 32'h1000, 32'h0,        4'hF, 32'hCAFEF00D, 1, 0, 4'hF};
        vecs[2] = '{1, 1, 32'h1004, 32'h12345678, 4'hC, 32'h0,        2, 1, 4'hC};
        vecs[3] = '{0, 0, 32'h104,  32'h0,        4'h0, 32'hA5A5A5A5, 5, 0, 4'hF};
        vecs[4] = '{1, 1, 32'h2003, 32'hFF000000, 4'h8, 32'h77,       TO - 1, 1, 4'h8};
        vecs[5] = '{0, 0, 32'h108,  32'h0,        4'h0, 32'h0BADF00D, 1, 0, 4'hF};
        @(negedge clk);
        #2;
        check("reset_state", {bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, if_ack_o, mem_ack_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Simultaneous requests: MEM store first, IF on the following IDLE.
        @(negedge clk);
        mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h2000; mem_wdata_i = 32'hDEADBEEF; mem_sel_i = 4'b0011;
        if_req_i = 1; if_addr_i = 32'h300;
        push(1, 0, 32'h0);
        push(0, 0, 32'h33334444);
        wait_busy("both_mem");
        check("both_mem_fields", {bus_addr_o, bus_we_o, bus_sel_o, bus_wdata_o}, {32'h2000, 1'b1, 4'b0011, 32'hDEADBEEF});
        check("both_if_stalled", stallreq_if_o, 1);
        slave_ack(2, 32'h0, 1, "both_mem");
        mem_req_i = 0;
        wait_busy("both_if");
        check("both_if_fields", {bus_addr_o, bus_we_o, bus_sel_o}, {32'h300, 1'b0, 4'hF});
        slave_ack(1, 32'h33334444, 0, "both_if");
        if_req_i = 0;

        // Continuous MEM with IF pending: four MEM grants, one IF, then MEM again.
        @(negedge clk);
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h4000; mem_sel_i = 4'hF;
        if_req_i = 1; if_addr_i = 32'h80;
        for (int g = 0; g < 6; g++) push(g != 4, 0, 32'h50 + 32'(g));
        for (int g = 0; g < 6; g++) begin
            wait_busy("streak");
            check("streak_owner", bus_addr_o, (g == 4) ? 32'h80 : 32'h4000);
            slave_ack(1, 32'h50 + 32'(g), g != 4, "streak");
            if (g == 4) if_req_i = 0;
            if (g == 5) mem_req_i = 0;
        end

        // Flush during a fetch: its ack is swallowed, the new address is fetched fresh.
        @(negedge clk);
        if_req_i = 1; if_addr_i = 32'h200;
        wait_busy("flush_first");
        check("flush_first_addr", bus_addr_o, 32'h200);
        @(negedge clk);
        if_flush_i = 1; if_addr_i = 32'h300;
        @(negedge clk);
        if_flush_i = 0;
        @(negedge clk);
        bus_ack_i = 1; bus_rdata_i = 32'hBAD0BAD0;
        #2;
        check("flush_dropped_ack", if_ack_o, 0);
        check("flush_still_stalled", stallreq_if_o, 1);
        @(negedge clk);
        bus_ack_i = 0; bus_rdata_i = 0;
        push(0, 0, 32'h03000300);
        wait_busy("flush_refetch");
        check("flush_refetch_addr", bus_addr_o, 32'h300);
        slave_ack(2, 32'h03000300, 0, "flush_refetch");
        if_req_i = 0;

        // Slave never answers a load: error ack on the last allowed busy cycle.
        @(negedge clk);
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h5000; mem_sel_i = 4'hF;
        bus_rdata_i = 32'hFFFFFFFF;
        push(1, 1, 32'h0);
        wait_busy("timeout");
        begin
            int k = 1;
            while (!mem_ack_o && k < 20) begin
                @(negedge clk);
                #2;
                k++;
            end
            check("timeout_busy_cycles", k, TO);
        end
        @(negedge clk);
        mem_req_i = 0; bus_rdata_i = 0;
        #2;
        check("timeout_bus_released", bus_req_o, 0);

        // Reset in the middle of a MEM transaction.
        @(negedge clk);
        mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h6000; mem_wdata_i = 32'h55; mem_sel_i = 4'hF;
        wait_busy("rst_mid");
        @(negedge clk);
        rst = 1;
        #2;
        check("rst_mid_outputs", {bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, if_ack_o, mem_ack_o}, 0);
        @(negedge clk);
        mem_req_i = 0;
        @(negedge clk);
        rst = 0;
        begin
            vec_t v = '{0, 0, 32'h700, 32'h0, 4'h0, 32'h77007700, 2, 0, 4'hF};
            do_txn(v);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
